// File: rtl/alu_mdu_seq.sv
// Sequential RV32I/RV32M execute unit: single-cycle base ALU ops, and
// one-bit-per-cycle shift-add multiply and restoring divide.
module alu_mdu_seq #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] rs1_i,
  input  logic [DWIDTH-1:0] rs2_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DWIDTH-1:0] res_o,
  output logic [AWIDTH-1:0] pc_o
);
  localparam int SW = $clog2(DWIDTH);
  localparam logic [DWIDTH-1:0] MOST_NEG = {1'b1, {(DWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_nxt;

  logic [2*DWIDTH-1:0] acc, acc_nxt, prod;
  logic [DWIDTH-1:0]   opnd, res_q, base_res, early_res, fin_res, quo, rem;
  logic [AWIDTH-1:0]   pc_q;
  logic [SW-1:0]       cnt;
  logic [2:0]          op;
  logic                neg_q, neg_r;
  logic                is_m, is_div, a_sgn, b_sgn, a_neg, b_neg, div0, ovf, accept, last;
  logic [DWIDTH-1:0]   a_mag, b_mag;
  logic [DWIDTH:0]     mul_sum, div_sh, div_diff;
  logic [SW-1:0]       shamt;

  // Operand decode at issue time
  always_comb begin
    is_m      = (funct7_i == 7'b0000001);
    is_div    = is_m && funct3_i[2];
    a_sgn     = is_div ? !funct3_i[0] : (funct3_i == 3'b001 || funct3_i == 3'b010);
    b_sgn     = is_div ? !funct3_i[0] : (funct3_i == 3'b001);
    a_neg     = a_sgn && rs1_i[DWIDTH-1];
    b_neg     = b_sgn && rs2_i[DWIDTH-1];
    a_mag     = a_neg ? -rs1_i : rs1_i;
    b_mag     = b_neg ? -rs2_i : rs2_i;
    div0      = (rs2_i == '0);
    ovf       = !funct3_i[0] && (rs1_i == MOST_NEG) && (&rs2_i);
    early_res = div0 ? (funct3_i[1] ? rs1_i : '1) : (funct3_i[1] ? '0 : MOST_NEG);
    accept    = valid_i && (state == IDLE) && !flush_i;
    last      = (cnt == SW'(DWIDTH-1));
    shamt     = rs2_i[SW-1:0];
  end

  always_comb begin
    base_res = '0;
    case (funct3_i)
      3'b000: base_res = funct7_i[5] ? rs1_i - rs2_i : rs1_i + rs2_i;
      3'b001: base_res = rs1_i << shamt;
      3'b010: base_res = {{(DWIDTH-1){1'b0}}, $signed(rs1_i) < $signed(rs2_i)};
      3'b011: base_res = {{(DWIDTH-1){1'b0}}, rs1_i < rs2_i};
      3'b100: base_res = rs1_i ^ rs2_i;
      3'b101: base_res = funct7_i[5] ? DWIDTH'($signed(rs1_i) >>> shamt) : rs1_i >> shamt;
      3'b110: base_res = rs1_i | rs2_i;
      default: base_res = rs1_i & rs2_i;
    endcase
  end

  // acc holds {partial/remainder, multiplier/dividend}; opnd is multiplicand/divisor
  always_comb begin
    mul_sum  = {1'b0, acc[2*DWIDTH-1:DWIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_sh   = acc[2*DWIDTH-1:DWIDTH-1];
    div_diff = div_sh - {1'b0, opnd};
    if (state == MUL)
      acc_nxt = {mul_sum, acc[DWIDTH-1:1]};
    else
      acc_nxt = {div_diff[DWIDTH] ? div_sh[DWIDTH-1:0] : div_diff[DWIDTH-1:0],
                 acc[DWIDTH-2:0], !div_diff[DWIDTH]};
    prod    = neg_q ? -acc_nxt : acc_nxt;
    quo     = neg_q ? -acc_nxt[DWIDTH-1:0] : acc_nxt[DWIDTH-1:0];
    rem     = neg_r ? -acc_nxt[2*DWIDTH-1:DWIDTH] : acc_nxt[2*DWIDTH-1:DWIDTH];
    if (state == MUL)
      fin_res = (op[1:0] == 2'b00) ? prod[DWIDTH-1:0] : prod[2*DWIDTH-1:DWIDTH];
    else
      fin_res = op[1] ? rem : quo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (valid_i) begin
        if (!is_m)                      state_nxt = DONE;
        else if (!is_div)               state_nxt = MUL;
        else if (div0 || ovf)           state_nxt = DONE;
        else                            state_nxt = DIV;
      end
      MUL, DIV: if (last) state_nxt = DONE;
      DONE:     if (ready_i) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (flush_i) state_nxt = IDLE;
  end

  always_comb begin
    ready_o = (state == IDLE);
    valid_o = (state == DONE);
    res_o   = res_q;
    pc_o    = pc_q;
  end

  // res_q is only written with a final result, never a partial one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      opnd  <= '0;
      cnt   <= '0;
      op    <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      res_q <= '0;
      pc_q  <= '0;
    end else if (accept) begin
      acc   <= {{DWIDTH{1'b0}}, a_mag};
      opnd  <= b_mag;
      cnt   <= '0;
      op    <= funct3_i;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      pc_q  <= pc_i;
      res_q <= is_m ? early_res : base_res;
    end else if ((state == MUL || state == DIV) && !flush_i) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
      if (last) res_q <= fin_res;
    end
  end
endmodule

// File: tb/tb_alu_mdu_seq.sv
// Bench for alu_mdu_seq: directed cases plus random ops against a
// plain-arithmetic reference, on 32-bit and 16-bit instances.
module tb_alu_mdu_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        v32, v16, flush, rdy_in;
  logic [31:0] pc, a, b;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        rdy32, vo32, rdy16, vo16;
  logic [31:0] res32, pco32, pco16;
  logic [15:0] res16;
  int total = 0, passes = 0;

  alu_mdu_seq #(.DWIDTH(32), .AWIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .valid_i(v32), .ready_o(rdy32), .pc_i(pc),
    .rs1_i(a), .rs2_i(b), .funct3_i(f3), .funct7_i(f7), .flush_i(flush),
    .valid_o(vo32), .ready_i(rdy_in), .res_o(res32), .pc_o(pco32));

  alu_mdu_seq #(.DWIDTH(16), .AWIDTH(32)) u16 (
    .clk(clk), .rst_n(rst_n), .valid_i(v16), .ready_o(rdy16), .pc_i(pc),
    .rs1_i(a[15:0]), .rs2_i(b[15:0]), .funct3_i(f3), .funct7_i(f7), .flush_i(flush),
    .valid_o(vo16), .ready_i(rdy_in), .res_o(res16), .pc_o(pco16));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: RISC-V semantics with 64-bit integer arithmetic, masked to w bits
  function automatic logic [31:0] ref_res(input int w, input logic [2:0] fn3,
                                          input logic [6:0] fn7, input logic [31:0] x, y);
    longint one = 1, mask, ua, ub, sa, sb, r;
    int sh;
    mask = (one << w) - 1;
    ua = longint'(x) & mask;
    ub = longint'(y) & mask;
    sa = (ua >= (one << (w - 1))) ? ua - (one << w) : ua;
    sb = (ub >= (one << (w - 1))) ? ub - (one << w) : ub;
    sh = int'(ub % w);
    r = 0;
    if (fn7 != 7'h01) begin
      case (fn3)
        3'd0: r = fn7[5] ? ua - ub : ua + ub;
        3'd1: r = ua << sh;
        3'd2: r = (sa < sb) ? 1 : 0;
        3'd3: r = (ua < ub) ? 1 : 0;
        3'd4: r = ua ^ ub;
        3'd5: r = fn7[5] ? (sa >>> sh) : (ua >> sh);
        3'd6: r = ua | ub;
        default: r = ua & ub;
      endcase
    end else begin
      case (fn3)
        3'd0: r = sa * sb;
        3'd1: r = (sa * sb) >>> w;
        3'd2: r = (sa * ub) >>> w;
        3'd3: r = (ua * ub) >> w;
        3'd4: r = (ub == 0) ? mask : (sa == -(one << (w - 1)) && sb == -1) ? ua : sa / sb;
        3'd5: r = (ub == 0) ? mask : ua / ub;
        3'd6: r = (ub == 0) ? ua : (sa == -(one << (w - 1)) && sb == -1) ? 0 : sa % sb;
        default: r = (ub == 0) ? ua : ua % ub;
      endcase
    end
    return 32'(r & mask);
  endfunction

  function automatic int ref_lat(input int w, input logic [2:0] fn3,
                                 input logic [6:0] fn7, input logic [31:0] x, y);
    logic [31:0] mask, mn;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    mn   = (w == 32) ? 32'h8000_0000 : 32'h0000_8000;
    if (fn7 != 7'h01) return 1;
    if (fn3[2] && ((y & mask) == 0)) return 1;
    if (fn3[2] && !fn3[0] && (x & mask) == mn && (y & mask) == mask) return 1;
    return w + 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h0000_8000;
      default: return $urandom;
    endcase
  endfunction

  task automatic run(input int w, input logic [2:0] fn3, input logic [6:0] fn7,
                     input logic [31:0] x, y);
    logic [31:0] exp, pcv;
    int exp_lat, lat, busy;
    exp     = ref_res(w, fn3, fn7, x, y);
    exp_lat = ref_lat(w, fn3, fn7, x, y);
    pcv     = $urandom;
    @(negedge clk);
    rdy_in = 1'b1; f3 = fn3; f7 = fn7; a = x; b = y; pc = pcv;
    if (w == 16) v16 = 1'b1; else v32 = 1'b1;
    chk("ready_idle", (w == 16) ? rdy16 : rdy32, 1'b1);
    @(posedge clk);
    #1 v16 = 1'b0; v32 = 1'b0;
    lat = 0; busy = 0;
    do begin
      @(negedge clk);
      lat++;
      if ((w == 16) ? rdy16 : rdy32) busy++;
    end while (!((w == 16) ? vo16 : vo32) && lat < 100);
    chk("latency", lat, exp_lat);
    chk("result", (w == 16) ? {16'h0, res16} : res32, exp);
    chk("pc", (w == 16) ? pco16 : pco32, pcv);
    chk("busy_ready", busy, 0);
  endtask

  initial begin
    int lat, bad, rise, kind;
    logic [2:0] rf3;
    logic [6:0] rf7;
    rst_n = 1'b0; v32 = 0; v16 = 0; flush = 0; rdy_in = 1; pc = 0; a = 0; b = 0; f3 = 0; f7 = 0;
    #12;
    chk("rst_ready", rdy32, 1'b1);
    chk("rst_valid", vo32, 1'b0);
    chk("rst_res", res32, 0);
    chk("rst_pc", pco32, 0);
    @(negedge clk) rst_n = 1'b1;

    run(32, 3'd0, 7'h00, 32'h7FFF_FFFF, 32'h1);
    run(32, 3'd0, 7'h20, 32'd5, 32'd7);
    run(32, 3'd5, 7'h20, 32'h8000_0000, 32'd4);
    run(32, 3'd1, 7'h01, 32'h8000_0000, 32'h8000_0000);
    run(32, 3'd2, 7'h01, 32'hFFFF_FFFF, 32'd2);
    run(32, 3'd0, 7'h01, 32'd7, 32'hFFFF_FFFD);
    run(32, 3'd4, 7'h01, 32'hFFFF_FFF9, 32'd2);
    run(32, 3'd6, 7'h01, 32'hFFFF_FFF9, 32'd2);
    run(32, 3'd5, 7'h01, 32'd100, 32'd0);
    run(32, 3'd6, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF);
    run(32, 3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF);

    // Backpressure: result must hold while the consumer stalls
    @(negedge clk);
    rdy_in = 0; f3 = 3'd5; f7 = 7'h01; a = 32'd10; b = 32'd3; v32 = 1;
    @(posedge clk);
    #1 v32 = 0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!vo32 && lat < 100);
    chk("bp_latency", lat, 33);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!(vo32 === 1'b1 && res32 === 32'd3 && rdy32 === 1'b0)) bad++;
    end
    chk("bp_hold", bad, 0);
    rdy_in = 1;
    @(negedge clk);
    chk("bp_release_valid", vo32, 1'b0);
    chk("bp_release_ready", rdy32, 1'b1);

    // Flush mid-multiply, with a competing op on the same cycle
    @(negedge clk);
    f3 = 3'd0; f7 = 7'h01; a = 32'd3; b = 32'd5; v32 = 1;
    @(posedge clk);
    #1 v32 = 0;
    repeat (10) @(negedge clk);
    flush = 1; v32 = 1; f3 = 3'd0; f7 = 7'h00; a = 32'd9; b = 32'd9;
    @(posedge clk);
    #1 flush = 0; v32 = 0;
    @(negedge clk);
    chk("flush_ready", rdy32, 1'b1);
    chk("flush_valid", vo32, 1'b0);
    rise = 0;
    repeat (40) begin @(negedge clk); if (vo32) rise++; end
    chk("flush_no_valid", rise, 0);
    run(32, 3'd0, 7'h00, 32'd1, 32'd1);

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    f3 = 3'd4; f7 = 7'h01; a = 32'd100; b = 32'd7; v32 = 1;
    @(posedge clk);
    #1 v32 = 0;
    repeat (5) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_ready", rdy32, 1'b1);
    chk("arst_valid", vo32, 1'b0);
    chk("arst_res", res32, 0);
    chk("arst_pc", pco32, 0);
    @(negedge clk) rst_n = 1;
    rise = 0;
    repeat (40) begin @(negedge clk); if (vo32) rise++; end
    chk("arst_no_valid", rise, 0);

    run(16, 3'd3, 7'h01, 32'hFFFF, 32'hFFFF);

    for (int i = 0; i < 50; i++) begin
      kind = $urandom_range(0, 2);
      rf3  = 3'($urandom_range(0, 7));
      rf7  = (kind != 0) ? 7'h01 :
             ((rf3 == 3'd0 || rf3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      run((i % 5 == 4) ? 16 : 32, rf3, rf7, pick(), pick());
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
